// File: rtl/stopwatch_ctrl.sv
// Push-button stopwatch: debounced start/stop and lap/reset keys drive a
// 10 ms time base and a 4-digit BCD counter (SS.hh) shown on active-low 7-segment digits.

module stopwatch_key #(
  parameter int DEB_CNT = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key,
  output logic press
);
  localparam int CW = $clog2(DEB_CNT + 1);
  localparam logic [CW-1:0] C_MAX = CW'(DEB_CNT);
  localparam logic [CW-1:0] C_PRE = CW'(DEB_CNT - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // press fires on the edge where cnt steps onto C_MAX; saturation keeps a held key to one event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key;
      s2    <= s1;
      press <= !s2 && (cnt == C_PRE);
      if (s2)
        cnt <= '0;
      else if (cnt != C_MAX)
        cnt <= cnt + 1'b1;
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int TICK_CNT = 500000,
  parameter int DEB_CNT  = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_key_ss,
  input  logic       i_key_lr,
  output logic       o_running,
  output logic       o_lap,
  output logic       o_wrap,
  output logic [6:0] o_seven0,
  output logic [6:0] o_seven1,
  output logic [6:0] o_seven2,
  output logic [6:0] o_seven3
);
  localparam int PW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam logic [PW-1:0]    P_LAST = PW'(TICK_CNT - 1);
  localparam logic [3:0][3:0] D_MAX  = {4'd5, 4'd9, 4'd9, 4'd9};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

  state_t          st, nxt;
  logic [1:0]      ev;
  logic            ev_ss, ev_lr;
  logic            counting, show_lap, cap, clr, tick, carry;
  logic [PW-1:0]   pre;
  logic [3:0][3:0] dig, dig_inc, lap_q, src;
  logic [3:0][6:0] seg;

  // ev[0] = start/stop, ev[1] = lap/reset
  stopwatch_key #(.DEB_CNT(DEB_CNT)) u_key [1:0] (
    .clk    (clk),
    .reset_n(reset_n),
    .key    ({i_key_lr, i_key_ss}),
    .press  (ev)
  );
  assign ev_ss = ev[0];
  assign ev_lr = ev[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= IDLE;
    else          st <= nxt;
  end

  // start/stop wins when both keys fire in the same clock
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    if (ev_ss) nxt = RUN;
      RUN:     if (ev_ss) nxt = PAUSE; else if (ev_lr) nxt = LAP;
      LAP:     if (ev_ss) nxt = PAUSE; else if (ev_lr) nxt = RUN;
      PAUSE:   if (ev_ss) nxt = RUN;   else if (ev_lr) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    counting = (st == RUN) || (st == LAP);
    show_lap = (st == LAP);
    cap      = (st == RUN)   && !ev_ss && ev_lr;
    clr      = (st == PAUSE) && !ev_ss && ev_lr;
  end

  assign tick = counting && (pre == P_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 pre <= '0;
    else if (clr || st == IDLE)   pre <= '0;
    else if (counting)            pre <= tick ? '0 : pre + 1'b1;
  end

  // decimal ripple: each digit rolls at its own limit and carries upward
  always_comb begin
    dig_inc = dig;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (dig[i] == D_MAX[i]) begin
          dig_inc[i] = 4'd0;
        end else begin
          dig_inc[i] = dig[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig    <= '0;
      lap_q  <= '0;
      o_wrap <= 1'b0;
    end else begin
      o_wrap <= tick && (dig == D_MAX);
      if (clr)       dig <= '0;
      else if (tick) dig <= dig_inc;
      if (cap)       lap_q <= dig;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_running <= 1'b0;
      o_lap     <= 1'b0;
    end else begin
      o_running <= (nxt == RUN) || (nxt == LAP);
      o_lap     <= (nxt == LAP);
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b100_0000;
      4'd1:    seg7 = 7'b111_1001;
      4'd2:    seg7 = 7'b010_0100;
      4'd3:    seg7 = 7'b011_0000;
      4'd4:    seg7 = 7'b001_1001;
      4'd5:    seg7 = 7'b001_0010;
      4'd6:    seg7 = 7'b000_0010;
      4'd7:    seg7 = 7'b111_1000;
      4'd8:    seg7 = 7'b000_0000;
      4'd9:    seg7 = 7'b001_0000;
      default: seg7 = 7'b111_1111;
    endcase
  endfunction

  assign src = show_lap ? lap_q : dig;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg <= {4{7'b111_1111}};
    end else begin
      for (int i = 0; i < 4; i++) seg[i] <= seg7(src[i]);
    end
  end

  assign o_seven0 = seg[0];
  assign o_seven1 = seg[1];
  assign o_seven2 = seg[2];
  assign o_seven3 = seg[3];
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Stopwatch bench: expectations are queued against absolute clock-edge numbers
// and compared on the falling edge when that edge comes round.

module tb_stopwatch_ctrl;
  localparam int TICK = 4;
  localparam int DEB  = 3;

  logic clk = 1'b0, reset_n = 1'b0, key_ss = 1'b1, key_lr = 1'b1;
  logic running, lap, wrap;
  logic [6:0] s0, s1, s2, s3;

  stopwatch_ctrl #(.TICK_CNT(TICK), .DEB_CNT(DEB)) dut (
    .clk(clk), .reset_n(reset_n), .i_key_ss(key_ss), .i_key_lr(key_lr),
    .o_running(running), .o_lap(lap), .o_wrap(wrap),
    .o_seven0(s0), .o_seven1(s1), .o_seven2(s2), .o_seven3(s3)
  );

  always #5 clk = ~clk;

  typedef struct { string name; int edge_no; int bcd; bit run; bit lp; bit wr; } exp_t;
  typedef struct { string name; int rel; int bcd; bit run; bit lp; } vec_t;

  exp_t       exp_q[$];
  exp_t       cur;
  vec_t       vc [10];
  vec_t       vd [12];
  logic [6:0] seg_lut [10];
  int cyc = 0, checks = 0, errors = 0, wrap_cnt = 0;

  // bcd < 0 means all digits blank
  function automatic logic [27:0] exp_segs(input int bcd);
    if (bcd < 0) return '1;
    return {seg_lut[bcd / 1000], seg_lut[(bcd / 100) % 10], seg_lut[(bcd / 10) % 10], seg_lut[bcd % 10]};
  endfunction

  task automatic cmp(input exp_t e);
    logic [27:0] want, got;
    want = exp_segs(e.bcd);
    got  = {s3, s2, s1, s0};
    checks++;
    if (got !== want || running !== e.run || lap !== e.lp || wrap !== e.wr) begin
      errors++;
      $display("FAIL %s edge %0d: got seg=%h run=%b lap=%b wrap=%b, want seg=%h run=%b lap=%b wrap=%b",
               e.name, cyc, got, running, lap, wrap, want, e.run, e.lp, e.wr);
    end
  endtask

  task automatic push(input string n, input int e, input int bcd, input bit r, input bit l, input bit w);
    exp_t x;
    x = '{n, e, bcd, r, l, w};
    exp_q.push_back(x);
  endtask

  task automatic clk1();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic to_edge(input int e);
    while (cyc < e) clk1();
  endtask

  // state change lands exactly 10 edges after the call
  task automatic press(input bit ss, input bit lr);
    repeat (4) clk1();
    if (ss) key_ss = 1'b0;
    if (lr) key_lr = 1'b0;
    repeat (6) clk1();
    key_ss = 1'b1;
    key_lr = 1'b1;
  endtask

  always @(negedge clk) begin
    if (wrap === 1'b1) wrap_cnt++;
    while (exp_q.size() > 0 && exp_q[0].edge_no <= cyc) begin
      cur = exp_q.pop_front();
      if (cur.edge_no < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for edge %0d not compared (now %0d)", cur.name, cur.edge_no, cyc);
      end else begin
        cmp(cur);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r0, r2, r3, w, p, i_e, r5;
    exp_t d;

    seg_lut[0] = 7'b100_0000; seg_lut[1] = 7'b111_1001; seg_lut[2] = 7'b010_0100;
    seg_lut[3] = 7'b011_0000; seg_lut[4] = 7'b001_1001; seg_lut[5] = 7'b001_0010;
    seg_lut[6] = 7'b000_0010; seg_lut[7] = 7'b111_1000; seg_lut[8] = 7'b000_0000;
    seg_lut[9] = 7'b001_0000;

    // run/pause/resume, offsets from the first RUN edge
    vc[0] = '{"c_0099", 400,  99, 1'b1, 1'b0};
    vc[1] = '{"c_0100", 401, 100, 1'b1, 1'b0};
    vc[2] = '{"p_enter", 411, 102, 1'b0, 1'b0};
    vc[3] = '{"p_hold1", 412, 102, 1'b0, 1'b0};
    vc[4] = '{"p_hold2", 460, 102, 1'b0, 1'b0};
    vc[5] = '{"r_resume", 480, 102, 1'b1, 1'b0};
    vc[6] = '{"r_frac", 481, 102, 1'b1, 1'b0};
    vc[7] = '{"r_tick", 482, 103, 1'b1, 1'b0};
    vc[8] = '{"r_run", 490, 105, 1'b1, 1'b0};
    vc[9] = '{"c_idle", 535, 0, 1'b0, 1'b0};

    // lap hold/release, ss+lr collision, pause clear
    vd[0]  = '{"d_run", 100, 24, 1'b1, 1'b0};
    vd[1]  = '{"lap_enter", 150, 37, 1'b1, 1'b1};
    vd[2]  = '{"lap_frz1", 151, 37, 1'b1, 1'b1};
    vd[3]  = '{"lap_frz2", 250, 37, 1'b1, 1'b1};
    vd[4]  = '{"lap_frz3", 309, 37, 1'b1, 1'b1};
    vd[5]  = '{"lap_exit", 310, 37, 1'b1, 1'b0};
    vd[6]  = '{"lap_live", 311, 77, 1'b1, 1'b0};
    vd[7]  = '{"lap_live2", 340, 84, 1'b1, 1'b0};
    vd[8]  = '{"both_pause", 361, 90, 1'b0, 1'b0};
    vd[9]  = '{"both_hold", 400, 90, 1'b0, 1'b0};
    vd[10] = '{"idle_clr", 421, 0, 1'b0, 1'b0};
    vd[11] = '{"idle_hold", 450, 0, 1'b0, 1'b0};

    // reset and first load
    repeat (3) clk1();
    d = '{"reset_blank", 0, -1, 1'b0, 1'b0, 1'b0};
    cmp(d);
    reset_n = 1'b1;
    push("rst_load", 4, 0, 0, 0, 0);
    push("idle_10", 10, 0, 0, 0, 0);
    push("idle_24", 24, 0, 0, 0, 0);
    to_edge(24);

    // bouncing key: never long enough to count
    push("bounce_a", 26, 0, 0, 0, 0);
    push("bounce_b", 34, 0, 0, 0, 0);
    push("bounce_c", 42, 0, 0, 0, 0);
    push("bounce_d", 48, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      key_ss = 1'b0; repeat (2) clk1();
      key_ss = 1'b1; repeat (2) clk1();
    end
    to_edge(48);

    // held 10 clocks: exactly one start
    key_ss = 1'b0;
    e0 = cyc + 1;
    for (int k = 0; k < 10; k++) push("hold_start", e0 + k, 0, k >= DEB + 2, 0, 0);
    repeat (10) clk1();
    key_ss = 1'b1;
    r0 = e0 + DEB + 2;

    foreach (vc[k]) push(vc[k].name, r0 + vc[k].rel, vc[k].bcd, vc[k].run, vc[k].lp, 1'b0);
    to_edge(r0 + 401); press(1, 0);
    to_edge(r0 + 470); press(1, 0);
    to_edge(r0 + 500); press(1, 0);
    to_edge(r0 + 520); press(0, 1);
    to_edge(r0 + 540); press(1, 0);
    r2 = cyc;

    foreach (vd[k]) push(vd[k].name, r2 + vd[k].rel, vd[k].bcd, vd[k].run, vd[k].lp, 1'b0);
    to_edge(r2 + 140); press(0, 1);
    to_edge(r2 + 300); press(0, 1);
    to_edge(r2 + 350); press(1, 1);
    to_edge(r2 + 410); press(0, 1);
    to_edge(r2 + 460); press(1, 0);
    r3 = cyc;

    // 6000th tick wraps 59.99; later pause lands on 12.34
    w   = r3 + 6000 * TICK;
    p   = r3 + 28937;
    i_e = p + 50;
    r5  = i_e + 70;
    push("wrap_pre", w - 1, 5999, 1, 0, 0);
    push("wrap_edge", w, 5999, 1, 0, 1);
    push("wrap_zero", w + 1, 0, 1, 0, 0);
    push("wrap_01", w + 5, 1, 1, 0, 0);
    push("wrap_02", w + 10, 2, 1, 0, 0);
    push("pause_1234", p + 1, 1234, 0, 0, 0);
    push("pause_1234h", p + 30, 1234, 0, 0, 0);
    push("clr_idle", i_e + 1, 0, 0, 0, 0);
    push("restart_t3", r5 + 4, 0, 1, 0, 0);
    push("restart_t4", r5 + 5, 1, 1, 0, 0);
    to_edge(p - 10);   press(1, 0);
    to_edge(p + 40);   press(0, 1);
    to_edge(i_e + 60); press(1, 0);
    to_edge(r5 + 20);

    // reset pulse mid-run
    reset_n = 1'b0;
    #1;
    d = '{"midrun_blank", 0, -1, 1'b0, 1'b0, 1'b0};
    cmp(d);
    clk1();
    d = '{"midrun_hold", 0, -1, 1'b0, 1'b0, 1'b0};
    cmp(d);
    reset_n = 1'b1;
    push("post_rst_load", r5 + 22, 0, 0, 0, 0);
    push("post_rst_idle", r5 + 40, 0, 0, 0, 0);
    to_edge(r5 + 45);

    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for edge %0d never reached", cur.name, cur.edge_no);
    end
    checks++;
    if (wrap_cnt != 1) begin
      errors++;
      $display("FAIL wrap_count: got %0d wrap pulses, want 1", wrap_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Push-button controlled stopwatch for the DE-board 7-segment bank: counts SS.hh (00.00–59.99) from the 50 MHz clock.
- Sequences its time-base/BCD datapath through IDLE/RUN/PAUSE/LAP and drives four active-low 7-segment digits plus status LEDs.
- Sits between the board KEY inputs and HEX0–HEX3.

Parameters:
TICK_CNT, 500000, clocks per 10 ms count step (50 MHz)
DEB_CNT, 1000000, consecutive low-sampled clocks required to accept a key press (20 ms)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
i_key_ss  input  1  start/stop key, active-low, asynchronous to clk
i_key_lr  input  1  lap/reset key, active-low, asynchronous to clk
o_running  output  1  high in RUN or LAP
o_lap  output  1  high in LAP
o_wrap  output  1  one-clock pulse when count wraps 59.99 -> 00.00
o_seven0  output  7  hundredths-units digit, active-low {g,f,e,d,c,b,a}
o_seven1  output  7  hundredths-tens digit
o_seven2  output  7  seconds-units digit
o_seven3  output  7  seconds-tens digit

Behaviour:
- Reset (async, reset_n low):
  - State IDLE; prescaler and all BCD digits 0; lap register 0.
  - o_running/o_lap/o_wrap 0; all o_sevenN 7'b111_1111 (blank).
  - Mid-operation reset aborts immediately. The first clock edge after release loads display 00.00 (each digit 7'b100_0000).
- Key input path, per key:
  - 2-flop synchronizer, then debounce counter.
  - Counter increments while the synchronized level is low, saturates at DEB_CNT, clears when it is high.
  - Press event is a 1-clock pulse on the edge where the counter reaches DEB_CNT. A held key yields exactly one event; re-arms only after release.
  - Event first visible DEB_CNT+2 clocks after the first edge sampling the key low.
- Time base:
  - Prescaler counts 0..TICK_CNT-1, advancing only in RUN and LAP.
  - Tick = 1-clock pulse when prescaler == TICK_CNT-1; prescaler wraps to 0 on the same edge.
  - PAUSE holds the prescaler (fraction preserved). IDLE holds it at 0.
- Counter: 4 BCD digits d3 d2 d1 d0.
  - Ranges: d0, d1, d2 are 0–9; d3 is 0–5. Increment on tick with decimal carry.
  - 59.99 + tick -> 00.00; o_wrap high for that one clock. Counting continues.
- FSM, evaluated on key events; if both events occur in the same clock, ss wins and lr is discarded:
  - IDLE: ss -> RUN; lr ignored.
  - RUN: ss -> PAUSE; lr -> LAP, capturing the current d3..d0 into the lap register on that edge.
  - LAP: lr -> RUN (display returns to live); ss -> PAUSE (display returns to live, paused value). Counting continues while in LAP.
  - PAUSE: ss -> RUN; lr -> IDLE, clearing digits and prescaler on that edge.
- Display:
  - Source = lap register in LAP, live digits otherwise.
  - Registered decode, 1 clock after the source changes.
  - Patterns, bit0 = a, low = lit:
    - 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001
    - 5=001_0010, 6=000_0010, 7=111_1000, 8=000_0000, 9=001_0000
- Status outputs: o_running and o_lap are registered from the next state, so they change on the same edge as the state.

Test Plan (TICK_CNT=4, DEB_CNT=3):
- Reset then release; idle 20 clocks -> o_sevenN = 7'b111_1111 during reset, 7'b100_0000 all digits after. o_running=0, o_lap=0.
- Key ss low 2 clocks then high (bounce), repeated 5 times -> no event, stays IDLE. Then hold low 10 clocks -> single event, o_running=1 at DEB_CNT+2 (+1 registered) clocks, one state change only.
- Start, run 400 clocks (100 ticks) -> digits 01.00 (o_seven2=111_1001, o_seven0/1/3=100_0000).
  - Press ss -> PAUSE, value frozen.
  - Press ss again -> resumes with the preserved prescaler fraction; next tick exactly 4 − elapsed-fraction clocks later.
- RUN, press lr at 00.37 -> o_lap=1, display frozen at 00.37 while the internal count advances.
  - Press lr after 40 more ticks -> display 00.77 (live), o_lap=0.
- Force count to 59.99 in RUN -> next tick shows 00.00 with o_wrap high exactly 1 clock.
  - Also: ss and lr events in the same clock from RUN -> PAUSE only, no lap capture.
- PAUSE at 12.34, press lr -> display 00.00, IDLE.
  - Also: assert reset_n low mid-RUN for 1 clock -> outputs blank immediately; IDLE 00.00 after release.
